spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  Synthesizable SPI-flash slave model, the parametrised successor of the bench-side flash emulation.
//  Serves the boot loader's SPI reads from a preloadable word memory.
//  Supports 0x03 READ, 0x0B FAST_READ, 0x9F JEDEC ID and 0x05 READ STATUS.
//  Address width, depth and SPI mode (CPOL/CPHA) are configurable.
//  Sits on the SoC SPI pins in FPGA/bench builds in place of external flash.
// PARAMETERS
//  DEPTH       512       number of 32-bit words in memory (power of 2)
//  ADDR_BYTES  3         address bytes following READ/FAST_READ (1..4)
//  CPOL        0         SPI clock idle level
//  CPHA        0         0: sample MOSI on leading edge; 1: sample on trailing edge
//  JEDEC_ID    24'hEF4016  3 bytes returned by 0x9F, MSB byte first
// PORTS
//  clock        in   1   system clock; io_spi_clk half-period >= 4 clock cycles
//  reset        in   1   asynchronous, active-high
//  io_spi_cs    in   1   chip select, active-low
//  io_spi_clk   in   1   SPI serial clock, asynchronous to clock
//  io_spi_mosi  in   1   serial data in
//  io_spi_miso  out  1   serial data out
//  load_en      in   1   word write strobe; memory preload
//  load_addr    in   $clog2(DEPTH)  word index for load
//  load_data    in   32  word written when load_en=1
//  busy         out  1   1 while io_spi_cs is low (synchronised)
//  rd_bytes     out  32  total data bytes served since reset; wraps at 2^32
// BEHAVIOUR
//  Clock and reset:
//  - One clock. Reset is asynchronous and active-high.
//  - On reset: io_spi_miso=0, busy=0, rd_bytes=0, state=IDLE.
//  - Memory contents are not reset.
//  Synchronisation:
//  - cs, sclk and mosi pass through 2-flop synchronisers.
//  - sclk edges are detected on the synchronised value against the previous one.
//  - Leading edge = transition away from CPOL.
//  - Sample edge = leading if CPHA=0, else trailing.
//  - Shift edge = the opposite edge.
//  - All bits are transferred MSB first.
//  Chip select:
//  - CS deassert (sync cs=1) from any state forces IDLE next clock.
//  - It also clears bit/byte counters and drives io_spi_miso=0.
//  - Valid in mid-byte and mid-data: the partial byte is discarded.
//  - CS assert moves IDLE->CMD with bit count 0.
//  State machine:
//  - CMD: shift in 8 bits. Next state by opcode:
//    - 0x03 -> ADDR
//    - 0x0B -> ADDR, then DUMMY
//    - 0x9F -> ID
//    - 0x05 -> STAT
//    - any other -> IGNORE
//  - ADDR: shift in ADDR_BYTES*8 bits into the byte address.
//  - DUMMY: 8 sample edges ignored (0x0B only).
//  - DATA: stream bytes from memory, starting at the received address.
//    - Word index = addr[2+:$clog2(DEPTH)]; higher address bits are ignored.
//    - Byte lane = addr[1:0]; lane 0 = word[7:0] (little-endian).
//    - After each byte the address increments.
//    - Wrap from byte DEPTH*4-1 to 0.
//    - rd_bytes increments once per completed byte.
//  - ID: sends JEDEC_ID[23:16], [15:8], [7:0]. Further bytes are 0x00.
//  - STAT: sends 0x00 repeatedly (never busy).
//  - IGNORE: io_spi_miso=0 until CS deasserts.
//  Output timing:
//  - CPHA=0: the first response bit is driven on the shift edge that ends the last cmd/addr/dummy bit.
//  - CPHA=1: the first response bit is driven on the first leading edge of the response phase.
//  - io_spi_miso changes only on shift edges.
//  - io_spi_miso is stable for >= 2 clock cycles before the master's sample edge at minimum sclk timing.
//  Memory loading:
//  - load_en writes are accepted in any state and take effect next clock.
//  - A read of the same word in the same cycle returns the old data.
//  - Byte fetch latency: 1 clock after the previous byte's last sample edge.
//    This is hidden by the >= 4-clock half-period requirement.
// TESTING
//  - Mode 0, load word0=32'h12345678: CS low, send 03 00 00 00, clock 4 bytes -> MISO bytes 78 56 34 12; rd_bytes=4.
//  - Wrap, DEPTH=512: READ at 0x0007FE with 4 bytes -> 2nd-half bytes of word 511, then word0 bytes 0 and 1.
//    rd_bytes advances by 4.
//  - FAST_READ 0x0B, addr 0x000004, one dummy byte, word1=32'hA5A5_0F0F -> 0F 0F A5 A5.
//  - 0x9F -> EF 40 16 00; 0x05 -> 00 00; opcode 0xFF -> MISO held 0 for 4 bytes.
//  - CS deasserted after bit 3 of a data byte -> busy=0 and MISO=0 within 3 clocks.
//    Next READ at 0 returns 78 first.
//  - Repeat the first scenario with CPOL=1,CPHA=1; async reset pulse mid-DATA -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
// Synthesizable SPI-flash slave. It answers READ (0x03), FAST_READ (0x0B),
// JEDEC ID (0x9F) and READ STATUS (0x05) from a word memory that can be
// preloaded from the system side. All SPI pins are asynchronous to clock
// and are oversampled through 2-flop synchronisers.
//
// Ports:
//   clock        system clock (SPI half-period must be >= 4 clocks)
//   reset        asynchronous, active-high
//   io_spi_cs    chip select, active-low
//   io_spi_clk   SPI serial clock
//   io_spi_mosi  serial data in
//   io_spi_miso  serial data out
//   load_en      memory preload write strobe
//   load_addr    word index for preload
//   load_data    word written when load_en=1
//   busy         1 while the synchronised chip select is low
//   rd_bytes     count of memory data bytes served since reset (wraps)

module spi_flash_responder #(
   parameter int          DEPTH      = 512,
   parameter int          ADDR_BYTES = 3,
   parameter bit          CPOL       = 1'b0,
   parameter bit          CPHA       = 1'b0,
   parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_spi_cs,
   input  logic                     io_spi_clk,
   input  logic                     io_spi_mosi,
   output logic                     io_spi_miso,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   output logic                     busy,
   output logic [31:0]              rd_bytes
);

   localparam int AW    = $clog2(DEPTH);
   localparam int BA    = AW + 2;
   localparam int ABITS = ADDR_BYTES * 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_ID     = 3'd5;
   localparam logic [2:0] S_STAT   = 3'd6;
   localparam logic [2:0] S_IGNORE = 3'd7;

   logic [1:0]    cs_sync;
   logic [1:0]    sclk_sync;
   logic [1:0]    mosi_sync;
   logic          sclk_prev;
   logic          cs_s;
   logic          sclk_s;
   logic          mosi_s;
   logic          sclk_change;
   logic          lead_edge;
   logic          trail_edge;
   logic          sample_edge;
   logic          shift_edge;

   logic [2:0]    state;
   logic [4:0]    bit_cnt;
   logic [2:0]    tx_bit;
   logic [1:0]    id_cnt;
   logic [6:0]    cmd_sr;
   logic [7:0]    opcode;
   logic [BA-1:0] addr;
   logic          is_fast;
   logic [7:0]    tx_sr;
   logic [7:0]    data_byte;
   logic [7:0]    next_byte;
   logic          responding;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   rdata;

   // Two-flop synchronisers for every SPI input. The clock synchroniser
   // resets to the idle level so no phantom edge is seen after reset, and
   // chip select resets to deasserted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cs_sync   <= 2'b11;
         sclk_sync <= {2{CPOL}};
         mosi_sync <= 2'b00;
         sclk_prev <= CPOL;
      end else begin
         cs_sync   <= {cs_sync[0], io_spi_cs};
         sclk_sync <= {sclk_sync[0], io_spi_clk};
         mosi_sync <= {mosi_sync[0], io_spi_mosi};
         sclk_prev <= sclk_sync[1];
      end
   end

   assign cs_s   = cs_sync[1];
   assign sclk_s = sclk_sync[1];
   assign mosi_s = mosi_sync[1];
   assign busy   = ~cs_s;

   // A leading edge leaves the idle level; the sample edge is the leading
   // one in CPHA=0 and the trailing one in CPHA=1, and MISO moves on the other.
   assign sclk_change = sclk_s ^ sclk_prev;
   assign lead_edge   = sclk_change && (sclk_prev == CPOL);
   assign trail_edge  = sclk_change && (sclk_prev != CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   assign opcode     = {cmd_sr, mosi_s};
   assign responding = (state == S_DATA) || (state == S_ID) || (state == S_STAT);

   // Word memory with a registered read of the current byte address. The
   // read always sees the pre-write contents when the same word is loaded
   // in the same cycle. The word is refetched every clock, so an address
   // increment is reflected one clock later, well before the next shift edge.
   always_ff @(posedge clock) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
      rdata <= mem[addr[BA-1:2]];
   end

   // Little-endian lane select: lane 0 is the least significant byte.
   always_comb begin
      data_byte = rdata[7:0];
      case (addr[1:0])
         2'd0:    data_byte = rdata[7:0];
         2'd1:    data_byte = rdata[15:8];
         2'd2:    data_byte = rdata[23:16];
         default: data_byte = rdata[31:24];
      endcase
   end

   // Byte to launch at the start of the next response byte. Status always
   // reads as not busy, and the ID sequence runs out into zeros.
   always_comb begin
      next_byte = 8'h00;
      case (state)
         S_DATA: next_byte = data_byte;
         S_ID: begin
            case (id_cnt)
               2'd0:    next_byte = JEDEC_ID[23:16];
               2'd1:    next_byte = JEDEC_ID[15:8];
               2'd2:    next_byte = JEDEC_ID[7:0];
               default: next_byte = 8'h00;
            endcase
         end
         default: next_byte = 8'h00;
      endcase
   end

   // Command sequencer. Chip select deassertion overrides everything and
   // throws away any partial byte. Inbound bits are taken on sample edges;
   // response bits are launched on shift edges once a response state is
   // entered, so in CPHA=0 the first bit goes out on the trailing edge that
   // closes the last command/address/dummy bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         bit_cnt     <= 5'd0;
         tx_bit      <= 3'd0;
         id_cnt      <= 2'd0;
         cmd_sr      <= 7'd0;
         addr        <= '0;
         is_fast     <= 1'b0;
         tx_sr       <= 8'd0;
         io_spi_miso <= 1'b0;
         rd_bytes    <= 32'd0;
      end else if (cs_s) begin
         state       <= S_IDLE;
         bit_cnt     <= 5'd0;
         tx_bit      <= 3'd0;
         id_cnt      <= 2'd0;
         is_fast     <= 1'b0;
         io_spi_miso <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state       <= S_CMD;
               bit_cnt     <= 5'd0;
               tx_bit      <= 3'd0;
               id_cnt      <= 2'd0;
               addr        <= '0;
               tx_sr       <= 8'd0;
               io_spi_miso <= 1'b0;
            end
            S_CMD: begin
               if (sample_edge) begin
                  cmd_sr  <= opcode[6:0];
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt <= 5'd0;
                     case (opcode)
                        8'h03: begin
                           state   <= S_ADDR;
                           is_fast <= 1'b0;
                        end
                        8'h0B: begin
                           state   <= S_ADDR;
                           is_fast <= 1'b1;
                        end
                        8'h9F:   state <= S_ID;
                        8'h05:   state <= S_STAT;
                        default: state <= S_IGNORE;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               if (sample_edge) begin
                  addr    <= {addr[BA-2:0], mosi_s};
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'(ABITS - 1)) begin
                     bit_cnt <= 5'd0;
                     state   <= is_fast ? S_DUMMY : S_DATA;
                  end
               end
            end
            S_DUMMY: begin
               if (sample_edge) begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt <= 5'd0;
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (sample_edge) begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt  <= 5'd0;
                     addr     <= addr + BA'(1);
                     rd_bytes <= rd_bytes + 32'd1;
                  end
               end
            end
            S_IGNORE: io_spi_miso <= 1'b0;
            default: ;
         endcase

         if (responding && shift_edge) begin
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd0) begin
               io_spi_miso <= next_byte[7];
               tx_sr       <= {next_byte[6:0], 1'b0};
               if ((state == S_ID) && (id_cnt != 2'd3)) begin
                  id_cnt <= id_cnt + 2'd1;
               end
            end else begin
               io_spi_miso <= tx_sr[7];
               tx_sr       <= {tx_sr[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder. Two instances share clock, reset and
// the preload bus: index 0 runs SPI mode 0 (CPOL=0,CPHA=0), index 1 runs
// mode 3 (CPOL=1,CPHA=1). A byte-addressed memory model predicts every
// byte returned by READ/FAST_READ, and per-instance byte counters predict
// rd_bytes.

module tb_spi_flash_responder;

   localparam int DEPTH = 512;
   localparam int HALF  = 6;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  cs;
   logic [1:0]  sclk;
   logic [1:0]  mosi;
   logic [1:0]  miso;
   logic [1:0]  busy;
   logic [31:0] rd_bytes [2];
   logic        load_en;
   logic [8:0]  load_addr;
   logic [31:0] load_data;

   int          total;
   int          bad;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] model_rd [2];
   logic [7:0]  rx_buf [8];

   always #5 clock = ~clock;

   spi_flash_responder #(
      .DEPTH(DEPTH), .ADDR_BYTES(3), .CPOL(1'b0), .CPHA(1'b0), .JEDEC_ID(24'hEF4016)
   ) dut0 (
      .clock(clock), .reset(reset),
      .io_spi_cs(cs[0]), .io_spi_clk(sclk[0]), .io_spi_mosi(mosi[0]), .io_spi_miso(miso[0]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy[0]), .rd_bytes(rd_bytes[0])
   );

   spi_flash_responder #(
      .DEPTH(DEPTH), .ADDR_BYTES(3), .CPOL(1'b1), .CPHA(1'b1), .JEDEC_ID(24'hEF4016)
   ) dut3 (
      .clock(clock), .reset(reset),
      .io_spi_cs(cs[1]), .io_spi_clk(sclk[1]), .io_spi_mosi(mosi[1]), .io_spi_miso(miso[1]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy[1]), .rd_bytes(rd_bytes[1])
   );

   // Expected byte at a flash byte address: bits above the memory size are
   // ignored and each word is stored little-endian.
   function automatic logic [7:0] model_byte(input int unsigned a);
      int unsigned wrapped;
      logic [31:0] w;
      wrapped = a % (DEPTH * 4);
      w = model_mem[wrapped / 4];
      w = w >> (8 * (wrapped % 4));
      return w[7:0];
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic load_word(input int idx, input logic [31:0] data);
      load_en   = 1'b1;
      load_addr = 9'(idx);
      load_data = data;
      wait_clk(1);
      load_en   = 1'b0;
      model_mem[idx] = data;
   endtask

   task automatic spi_start(input int m);
      cs[m] = 1'b0;
      wait_clk(4);
   endtask

   task automatic spi_stop(input int m);
      wait_clk(HALF);
      cs[m] = 1'b1;
      wait_clk(6);
   endtask

   // Master side of one byte (or its first nbits), MSB first. MISO is read
   // just before the master's sample edge.
   task automatic spi_byte(input int m, input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (m == 0) begin
            mosi[m] = tx[i];
            wait_clk(HALF);
            rx[i] = miso[m];
            sclk[m] = 1'b1;
            wait_clk(HALF);
            sclk[m] = 1'b0;
         end else begin
            sclk[m] = 1'b0;
            mosi[m] = tx[i];
            wait_clk(HALF);
            rx[i] = miso[m];
            sclk[m] = 1'b1;
            wait_clk(HALF);
         end
      end
   endtask

   task automatic spi_txn(input int m, input logic [7:0] op, input logic [23:0] addr,
                          input int n);
      logic [7:0] junk;
      spi_start(m);
      spi_byte(m, op, 8, junk);
      if (op == 8'h03 || op == 8'h0B) begin
         spi_byte(m, addr[23:16], 8, junk);
         spi_byte(m, addr[15:8], 8, junk);
         spi_byte(m, addr[7:0], 8, junk);
      end
      if (op == 8'h0B) begin
         spi_byte(m, 8'($urandom), 8, junk);
      end
      for (int i = 0; i < n; i++) begin
         spi_byte(m, 8'($urandom), 8, rx_buf[i]);
      end
      spi_stop(m);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      cs        = 2'b11;
      sclk      = 2'b10;
      mosi      = 2'b00;
      load_en   = 1'b0;
      load_addr = 9'd0;
      load_data = 32'd0;
      wait_clk(3);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (miso[m] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_miso[%0d] got=%b want=0", m, miso[m]);
         end
         total++;
         if (busy[m] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy[%0d] got=%b want=0", m, busy[m]);
         end
         total++;
         if (rd_bytes[m] !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_rd_bytes[%0d] got=%0d want=0", m, rd_bytes[m]);
         end
         model_rd[m] = 32'd0;
      end
      reset = 1'b0;
      wait_clk(4);
      for (int i = 0; i < DEPTH; i++) begin
         load_word(i, $urandom);
      end
   endtask

   task automatic check_read(input string name, input int m, input int unsigned addr,
                             input int n);
      for (int i = 0; i < n; i++) begin
         total++;
         if (rx_buf[i] !== model_byte(addr + i)) begin
            bad++;
            $display("[TB] FAIL %s[%0d] mode=%0d addr=%h got=%h want=%h", name, i, m, addr,
                     rx_buf[i], model_byte(addr + i));
         end
      end
      model_rd[m] = model_rd[m] + 32'(n);
      total++;
      if (rd_bytes[m] !== model_rd[m]) begin
         bad++;
         $display("[TB] FAIL %s_rd_bytes mode=%0d got=%0d want=%0d", name, m, rd_bytes[m],
                  model_rd[m]);
      end
   endtask

   task automatic test_read(input int m);
      load_word(0, 32'h12345678);
      spi_txn(m, 8'h03, 24'h000000, 4);
      total++;
      if ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]} !== 32'h78563412) begin
         bad++;
         $display("[TB] FAIL read_word0 mode=%0d got=%h%h%h%h want=78563412", m,
                  rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]);
      end
      check_read("read", m, 0, 4);
   endtask

   task automatic test_wrap();
      spi_txn(0, 8'h03, 24'h0007FE, 4);
      check_read("wrap", 0, 32'h7FE, 4);
   endtask

   task automatic test_fast_read();
      load_word(1, 32'hA5A5_0F0F);
      spi_txn(0, 8'h0B, 24'h000004, 4);
      total++;
      if ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]} !== 32'h0F0FA5A5) begin
         bad++;
         $display("[TB] FAIL fast_read got=%h%h%h%h want=0F0FA5A5",
                  rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]);
      end
      check_read("fast_read", 0, 4, 4);
   endtask

   task automatic test_id_status_ignore(input int m);
      logic [31:0] got;
      spi_txn(m, 8'h9F, 24'h0, 4);
      got = {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]};
      total++;
      if (got !== 32'hEF401600) begin
         bad++;
         $display("[TB] FAIL jedec_id mode=%0d got=%h want=EF401600", m, got);
      end
      spi_txn(m, 8'h05, 24'h0, 2);
      got = {16'h0, rx_buf[0], rx_buf[1]};
      total++;
      if (got !== 32'h0) begin
         bad++;
         $display("[TB] FAIL status mode=%0d got=%h want=0000", m, got[15:0]);
      end
      spi_txn(m, 8'hFF, 24'h0, 4);
      got = {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]};
      total++;
      if (got !== 32'h0) begin
         bad++;
         $display("[TB] FAIL ignore mode=%0d got=%h want=00000000", m, got);
      end
      total++;
      if (rd_bytes[m] !== model_rd[m]) begin
         bad++;
         $display("[TB] FAIL non_read_rd_bytes mode=%0d got=%0d want=%0d", m, rd_bytes[m],
                  model_rd[m]);
      end
   endtask

   task automatic test_abort();
      logic [7:0] junk;
      spi_start(0);
      spi_byte(0, 8'h03, 8, junk);
      spi_byte(0, 8'h00, 8, junk);
      spi_byte(0, 8'h00, 8, junk);
      spi_byte(0, 8'h00, 8, junk);
      spi_byte(0, 8'h00, 4, junk);
      total++;
      if (busy[0] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_busy_before got=%b want=1", busy[0]);
      end
      cs[0] = 1'b1;
      wait_clk(3);
      total++;
      if (busy[0] !== 1'b0 || miso[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_outputs busy=%b miso=%b want=0,0", busy[0], miso[0]);
      end
      wait_clk(4);
      total++;
      if (rd_bytes[0] !== model_rd[0]) begin
         bad++;
         $display("[TB] FAIL abort_rd_bytes got=%0d want=%0d", rd_bytes[0], model_rd[0]);
      end
      spi_txn(0, 8'h03, 24'h000000, 1);
      total++;
      if (rx_buf[0] !== 8'h78) begin
         bad++;
         $display("[TB] FAIL abort_reread got=%h want=78", rx_buf[0]);
      end
      check_read("abort_reread", 0, 0, 1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         int          m;
         logic [7:0]  op;
         logic [23:0] addr;
         int          n;
         m    = int'($urandom_range(0, 1));
         op   = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B;
         addr = 24'($urandom);
         n    = int'($urandom_range(1, 5));
         if ($urandom_range(0, 1) == 1) begin
            load_word(int'(addr[10:2]), $urandom);
         end
         spi_txn(m, op, addr, n);
         check_read("random", m, 32'(addr), n);
      end
   endtask

   task automatic test_reset_mid_data();
      logic [7:0] junk;
      spi_start(1);
      spi_byte(1, 8'h03, 8, junk);
      spi_byte(1, 8'h00, 8, junk);
      spi_byte(1, 8'h00, 8, junk);
      spi_byte(1, 8'h00, 8, junk);
      spi_byte(1, 8'h00, 8, junk);
      spi_byte(1, 8'h00, 3, junk);
      reset = 1'b1;
      wait_clk(1);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (miso[m] !== 1'b0 || busy[m] !== 1'b0 || rd_bytes[m] !== 32'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset[%0d] miso=%b busy=%b rd_bytes=%0d want=0,0,0", m,
                     miso[m], busy[m], rd_bytes[m]);
         end
         model_rd[m] = 32'd0;
      end
      cs[1]   = 1'b1;
      sclk[1] = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      wait_clk(6);
      spi_txn(1, 8'h03, 24'h000010, 3);
      check_read("after_reset", 1, 32'h10, 3);
   endtask

   initial begin
      repeat (100000) @(posedge clock);
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_read(0);
      test_read(1);
      test_wrap();
      test_fast_read();
      test_id_status_ignore(0);
      test_id_status_ignore(1);
      test_abort();
      test_random();
      test_reset_mid_data();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
